// File: rtl/mem_pkg.sv
// Shared types and lane constants for the MIPS load/store unit.
package mem_pkg;

  // Access size as encoded on the EX/MEM request bus.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_LOAD_RSP,
    ST_MERGE_WR,
    ST_ERR
  } state_e;

  localparam bit BIG_ENDIAN = 1'b1;

  // MSB position of each byte lane within the word, indexed by byte offset (big-endian order).
  localparam int unsigned BYTE_MSB [0:3] = '{31, 23, 15, 7};

  // MSB of the byte lane selected by a byte offset.
  function automatic int unsigned lane_msb(input logic [1:0] offset);
    return BIG_ENDIAN ? BYTE_MSB[offset] : BYTE_MSB[~offset];
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
import mem_pkg::*;

module mem_access_unit_lane_align (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half lane out of the memory word.
  always_comb begin
    byte_sel = word[lane_msb(offset) -: 8];
    half_sel = offset[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane for loads; word loads pass straight through.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    load_data = word;
    unique case (size)
      SZ_BYTE: load_data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Replace only the target lane with the right-aligned store data.
  always_comb begin
    merge_data = word;
    unique case (size)
      SZ_BYTE: merge_data[lane_msb(offset) -: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) merge_data[15:0]  = wdata[15:0];
        else           merge_data[31:16] = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller: accepts byte-addressed requests and drives a word-wide
// synchronous-read data memory, using read-modify-write for sub-word stores.
import mem_pkg::*;

module mem_access_unit #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_read,
  input  logic          req_write,
  input  size_e         req_size,
  input  logic          req_unsigned,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_w_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_in,
  input  logic [DW-1:0] mem_d_out
);

  state_e        state, state_next;
  logic          is_load_q;
  size_e         size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [DW-1:0] wdata_q;
  logic          accept;
  logic          req_bad;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merge_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // Flag requests that must not touch memory: ambiguous direction, illegal size, misalignment.
  always_comb begin
    req_bad = (req_read == req_write) || (req_size == SZ_BAD) ||
              (req_size == SZ_HALF && req_addr[0]) ||
              (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

  // State register; reset drops mem_w_en at once since it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Capture request fields and the memory word address on accept only.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the capture registers are reset so mem_addr and the datapath start from a known 0.
    if (!rst_n) begin
      is_load_q <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      mem_addr  <= '0;
    end else if (accept) begin
      is_load_q <= req_read;
      size_q    <= req_size;
      uns_q     <= req_unsigned;
      off_q     <= req_addr[1:0];
      wdata_q   <= req_wdata;
      mem_addr  <= req_addr[AW+1:2];
    end
  end

  mem_access_unit_lane_align u_lane_align (
    .word       (mem_d_out),
    .offset     (off_q),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state and per-state outputs.
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    mem_w_en   = 1'b0;
    mem_d_in   = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)                          state_next = ST_ERR;
          else if (req_write && req_size == SZ_WORD) state_next = ST_WRITE;
          else                                  state_next = ST_READ;
        end
      end
      ST_READ: state_next = is_load_q ? ST_LOAD_RSP : ST_MERGE_WR;
      ST_WRITE: begin
        mem_w_en   = 1'b1;
        mem_d_in   = wdata_q;
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_LOAD_RSP: begin
        rsp_rdata  = load_data;
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_MERGE_WR: begin
        mem_w_en   = 1'b1;
        mem_d_in   = merge_data;
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        rsp_valid  = 1'b1;
        rsp_err    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous-read data memory.
import mem_pkg::*;

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read, req_write, req_unsigned;
  size_e       req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, mem_w_en;
  logic [31:0] rsp_rdata, mem_d_in, mem_d_out;
  logic [9:0]  mem_addr;

  logic [31:0] dmem [0:1023];

  int tests = 0;
  int fails = 0;

  int          r_lat;
  logic [31:0] r_rdata, r_din;
  logic        r_err, r_wen, r_wen_any;
  logic [9:0]  r_maddr;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(10), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_w_en     (mem_w_en),
    .mem_addr     (mem_addr),
    .mem_d_in     (mem_d_in),
    .mem_d_out    (mem_d_out)
  );

  // Word-wide data memory: registered read, whole-word write.
  always @(posedge clk) begin
    if (mem_w_en) dmem[mem_addr] <= mem_d_in;
    mem_d_out <= dmem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request as soon as the unit is ready and record the response cycle.
  task automatic do_req(input logic rd, input logic wr, input size_e sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    r_lat = 0; r_wen_any = 1'b0;
    r_rdata = 'x; r_err = 1'bx; r_wen = 1'bx; r_maddr = 'x; r_din = 'x;
    for (int c = 1; c <= 6; c++) begin
      r_wen_any |= mem_w_en;
      if (rsp_valid) begin
        r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err;
        r_wen = mem_w_en; r_maddr = mem_addr; r_din = mem_d_in;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ld(input string tag, input size_e sz, input logic uns,
                    input logic [11:0] a, input logic [31:0] exp);
    do_req(1'b1, 1'b0, sz, uns, a, 32'h0);
    check({tag, "_lat"}, r_lat, 32'd2);
    check({tag, "_data"}, r_rdata, exp);
    check({tag, "_err"}, {31'b0, r_err}, 32'd0);
    check({tag, "_nowen"}, {31'b0, r_wen_any}, 32'd0);
  endtask

  task automatic st(input string tag, input size_e sz, input logic [11:0] a,
                    input logic [31:0] wd, input int lat, input logic [31:0] din);
    do_req(1'b0, 1'b1, sz, 1'b0, a, wd);
    check({tag, "_lat"}, r_lat, lat);
    check({tag, "_wen"}, {31'b0, r_wen}, 32'd1);
    check({tag, "_addr"}, {22'b0, r_maddr}, {22'b0, a[11:2]});
    check({tag, "_din"}, r_din, din);
    check({tag, "_rdata0"}, r_rdata, 32'd0);
  endtask

  task automatic er(input string tag, input logic rd, input logic wr, input size_e sz,
                    input logic [11:0] a, input logic [31:0] wd);
    do_req(rd, wr, sz, 1'b0, a, wd);
    check({tag, "_lat"}, r_lat, 32'd1);
    check({tag, "_err"}, {31'b0, r_err}, 32'd1);
    check({tag, "_nowen"}, {31'b0, r_wen_any}, 32'd0);
    check({tag, "_rdata0"}, r_rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_wen", {31'b0, mem_w_en}, 32'd0);
    check("rst_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_din", mem_d_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load.
    st("sw_008", SZ_WORD, 12'h008, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    ld("lw_008", SZ_WORD, 1'b0, 12'h008, 32'hDEADBEEF);
    @(negedge clk);
    check("addr_hold_idle", {22'b0, mem_addr}, 32'd2);

    // Byte loads, big-endian lanes.
    st("sw_004", SZ_WORD, 12'h004, 32'h11223344, 1, 32'h11223344);
    ld("lb_006", SZ_BYTE, 1'b0, 12'h006, 32'h00000033);
    ld("lb_004", SZ_BYTE, 1'b0, 12'h004, 32'h00000011);
    ld("lbu_007", SZ_BYTE, 1'b1, 12'h007, 32'h00000044);

    // Half loads with sign/zero extension.
    st("sw_00c", SZ_WORD, 12'h00C, 32'h80FF7F01, 1, 32'h80FF7F01);
    ld("lh_00c", SZ_HALF, 1'b0, 12'h00C, 32'hFFFF80FF);
    ld("lhu_00c", SZ_HALF, 1'b1, 12'h00C, 32'h000080FF);
    ld("lh_00e", SZ_HALF, 1'b0, 12'h00E, 32'h00007F01);
    ld("lb_00c", SZ_BYTE, 1'b0, 12'h00C, 32'hFFFFFF80);
    ld("lw_00c_uns", SZ_WORD, 1'b1, 12'h00C, 32'h80FF7F01);

    // Sub-word stores via read-modify-write; upper store data bits ignored.
    st("sw_010", SZ_WORD, 12'h010, 32'hAABBCCDD, 1, 32'hAABBCCDD);
    st("sb_011", SZ_BYTE, 12'h011, 32'hFFFFFF5A, 2, 32'hAA5ACCDD);
    ld("lw_010_a", SZ_WORD, 1'b0, 12'h010, 32'hAA5ACCDD);
    st("sh_012", SZ_HALF, 12'h012, 32'hFFFF1234, 2, 32'hAA5A1234);
    ld("lw_010_b", SZ_WORD, 1'b0, 12'h010, 32'hAA5A1234);
    ld("lw_014_untouched", SZ_WORD, 1'b0, 12'h014, 32'h00000000);

    // Error cases: no memory write, one-cycle error response.
    er("err_lw_002", 1'b1, 1'b0, SZ_WORD, 12'h002, 32'h0);
    er("err_lh_001", 1'b1, 1'b0, SZ_HALF, 12'h001, 32'h0);
    er("err_size11", 1'b1, 1'b0, SZ_BAD, 12'h000, 32'h0);
    er("err_rd_wr", 1'b1, 1'b1, SZ_WORD, 12'h008, 32'h0BADF00D);
    er("err_none", 1'b0, 1'b0, SZ_WORD, 12'h008, 32'h0);
    er("err_sw_00a", 1'b0, 1'b1, SZ_WORD, 12'h00A, 32'h12345678);
    er("err_sh_013", 1'b0, 1'b1, SZ_HALF, 12'h013, 32'h00005555);
    ld("lw_008_after_err", SZ_WORD, 1'b0, 12'h008, 32'hDEADBEEF);
    ld("lw_010_after_err", SZ_WORD, 1'b0, 12'h010, 32'hAA5A1234);

    // Reset asserted during MERGE_WR aborts the write.
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = SZ_BYTE;
    req_addr = 12'h011; req_wdata = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(posedge clk);
    #1;
    check("abort_merge_wen", {31'b0, mem_w_en}, 32'd1);
    check("abort_merge_din", mem_d_in, 32'hAA771234);
    rst_n = 1'b0;
    #1;
    check("abort_wen_low", {31'b0, mem_w_en}, 32'd0);
    check("abort_rsp_low", {31'b0, rsp_valid}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_addr0", {22'b0, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    ld("lw_010_after_abort", SZ_WORD, 1'b0, 12'h010, 32'hAA5A1234);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
